// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with an optional 2-entry skid buffer, synchronous flush
// and a saturating count of beats discarded by flush.
module pipe_stage_skid #(
    parameter int DATA_W         = 101,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              in_ready_q, in_ready_d;
    logic              acc_s, dlv_s;

    // Adds a small increment to the drop counter, pinning at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // With SKID=0 only one entry exists, so ready must see same-cycle downstream accepts.
    assign in_ready   = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_q;
    assign occupancy  = state_q;
    assign drop_count = drop_q;
    assign acc_s      = in_valid && in_ready;
    assign dlv_s      = out_valid && out_ready;

    // Next-state, payload and drop-counter logic; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        drop_d  = drop_q;
        if (flush) begin
            state_d = ST_EMPTY;
            drop_d  = sat_add(drop_q, occupancy + {1'b0, acc_s});
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = {DATA_W{1'b0}};
                skid_d = {DATA_W{1'b0}};
            end else begin
                main_d = main_q;
                skid_d = skid_q;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && dlv_s) begin
                        main_d = in_data;
                    end else if (acc_s) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (dlv_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (dlv_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    // State, payload and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= {DATA_W{1'b0}};
            skid_q     <= {DATA_W{1'b0}};
            drop_q     <= {CNT_W{1'b0}};
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            drop_q     <= drop_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: per-cycle vectors check handshake state, while
// scoreboard monitors check every delivered beat against the queue of accepted beats.
module tb_pipe_stage_skid;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          flush_a, in_valid_a, out_ready_a;
    logic [DW-1:0] in_data_a;
    logic          in_ready_a, out_valid_a, in_ready_c, out_valid_c;
    logic [DW-1:0] out_data_a, out_data_c;
    logic [1:0]    occ_a, occ_c, drop_c;
    logic [7:0]    drop_a;

    logic          flush_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b;
    logic [DW-1:0] in_data_b, out_data_b;
    logic [1:0]    occ_b;
    logic [7:0]    drop_b;

    int            checks = 0;
    int            passes = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(8)) u_a (
        .clk(clk), .reset_n(reset_n), .flush(flush_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_data(in_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .occupancy(occ_a), .drop_count(drop_a));

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(2)) u_c (
        .clk(clk), .reset_n(reset_n), .flush(flush_a), .in_valid(in_valid_a),
        .in_ready(in_ready_c), .in_data(in_data_a), .out_valid(out_valid_c),
        .out_ready(out_ready_a), .out_data(out_data_c), .occupancy(occ_c), .drop_count(drop_c));

    pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CLEAR_ON_FLUSH(1), .CNT_W(8)) u_b (
        .clk(clk), .reset_n(reset_n), .flush(flush_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_data(in_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .occupancy(occ_b), .drop_count(drop_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One cycle on the SKID=1 pair: drive, then check the state left by the previous edge.
    task automatic cyc_a(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl,
                         input logic e_ir, input logic [1:0] e_occ, input logic e_ov,
                         input logic od_en, input logic [DW-1:0] e_od,
                         input logic [7:0] e_da, input logic [1:0] e_dc);
        @(posedge clk);
        #1;
        in_valid_a = v; in_data_a = d; out_ready_a = rdy; flush_a = fl;
        #1;
        chk("a_in_ready", 32'(in_ready_a), 32'(e_ir));
        chk("a_occupancy", 32'(occ_a), 32'(e_occ));
        chk("a_out_valid", 32'(out_valid_a), 32'(e_ov));
        if (od_en) chk("a_out_data_head", 32'(out_data_a), 32'(e_od));
        chk("a_drop_count", 32'(drop_a), 32'(e_da));
        chk("c_drop_count_sat", 32'(drop_c), 32'(e_dc));
        if (fl) qa.delete();
        else if (v && e_ir) qa.push_back(d);
    endtask

    task automatic cyc_b(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl,
                         input logic e_ir, input logic [1:0] e_occ, input logic e_ov,
                         input logic od_en, input logic [DW-1:0] e_od, input logic [7:0] e_db);
        @(posedge clk);
        #1;
        in_valid_b = v; in_data_b = d; out_ready_b = rdy; flush_b = fl;
        #1;
        chk("b_in_ready", 32'(in_ready_b), 32'(e_ir));
        chk("b_occupancy", 32'(occ_b), 32'(e_occ));
        chk("b_out_valid", 32'(out_valid_b), 32'(e_ov));
        if (od_en) chk("b_out_data_head", 32'(out_data_b), 32'(e_od));
        chk("b_drop_count", 32'(drop_b), 32'(e_db));
        if (fl) qb.delete();
        else if (v && e_ir) qb.push_back(d);
    endtask

    // Scoreboard monitors; a head shown during flush is discarded, not delivered.
    always @(negedge clk) begin
        if (reset_n && !flush_a && out_valid_a && out_ready_a) begin
            chk("a_beat_pending", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) chk("a_out_data", 32'(out_data_a), 32'(qa.pop_front()));
        end
        if (reset_n && !flush_b && out_valid_b && out_ready_b) begin
            chk("b_beat_pending", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) chk("b_out_data", 32'(out_data_b), 32'(qb.pop_front()));
        end
    end

    initial begin
        reset_n = 1'b1;
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = 16'h0000;
        flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = 16'h0000;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_a_in_ready", 32'(in_ready_a), 32'd1);
        chk("rst_a_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_a_out_data", 32'(out_data_a), 32'd0);
        chk("rst_a_occupancy", 32'(occ_a), 32'd0);
        chk("rst_a_drop", 32'(drop_a), 32'd0);
        chk("rst_b_in_ready", 32'(in_ready_b), 32'd1);
        chk("rst_b_out_valid", 32'(out_valid_b), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Streaming, then backpressure into FULL with a refused beat 0x0C.
        cyc_a(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0, 2'd0);
        cyc_a(1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0001, 8'd0, 2'd0);
        cyc_a(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0002, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0003, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0, 2'd0);
        cyc_a(1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0, 2'd0);
        cyc_a(1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h000A, 8'd0, 2'd0);
        cyc_a(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'h000A, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'h000A, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'h000A, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h000B, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0, 2'd0);
        // Flush while FULL (in_ready low, so only the two held beats count), twice.
        cyc_a(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0, 2'd0);
        cyc_a(1'b1, 16'h0012, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0011, 8'd0, 2'd0);
        cyc_a(1'b1, 16'h0013, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 16'h0011, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd2, 2'd2);
        cyc_a(1'b1, 16'h0021, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd2, 2'd2);
        cyc_a(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0021, 8'd2, 2'd2);
        cyc_a(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 16'h0021, 8'd2, 2'd2);
        cyc_a(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd4, 2'd3);
        // Flush while ONE with a beat accepted and the head delivered: both count.
        cyc_a(1'b1, 16'h0031, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd4, 2'd3);
        cyc_a(1'b1, 16'h0032, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0031, 8'd4, 2'd3);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd6, 2'd3);
        // Asynchronous reset in the middle of a burst.
        cyc_a(1'b1, 16'h0041, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd6, 2'd3);
        cyc_a(1'b1, 16'h0042, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0041, 8'd6, 2'd3);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_a_out_valid", 32'(out_valid_a), 32'd0);
        chk("mid_rst_a_out_data", 32'(out_data_a), 32'd0);
        chk("mid_rst_a_occupancy", 32'(occ_a), 32'd0);
        chk("mid_rst_a_in_ready", 32'(in_ready_a), 32'd1);
        chk("mid_rst_a_drop", 32'(drop_a), 32'd0);
        chk("mid_rst_c_drop", 32'(drop_c), 32'd0);
        in_valid_a = 1'b0; out_ready_a = 1'b0;
        qa.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc_a(1'b1, 16'h0051, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0051, 8'd0, 2'd0);
        cyc_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0, 2'd0);

        // SKID=0: combinational ready, bubble-free replacement, then flush.
        cyc_b(1'b1, 16'h0061, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0);
        cyc_b(1'b1, 16'h0062, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'h0061, 8'd0);
        cyc_b(1'b1, 16'h0062, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0061, 8'd0);
        cyc_b(1'b1, 16'h0063, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0062, 8'd0);
        cyc_b(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0063, 8'd0);
        cyc_b(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0);
        cyc_b(1'b1, 16'h0071, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 8'd0);
        cyc_b(1'b1, 16'h0072, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0071, 8'd0);
        cyc_b(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd2);

        @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
